// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: binary32 field layout, rounding modes
// and the exception-flag pair produced by the float-to-integer converter.
package fpu_pkg;

  localparam int F32_W     = 32;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;
  localparam logic [F32_EXP_W-1:0] F32_EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/ftoi_pipe_if.sv
// Valid/ready stream bundle around the float-to-integer converter: operand
// beat in, integer result plus flags out.
interface ftoi_pipe_if
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input logic clk
);

  logic                 in_valid;
  logic                 in_ready;
  logic [F32_W-1:0]     x;
  logic [2:0]           rm;
  logic                 is_unsigned;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     y;
  flags_t               flags;

  modport master (
    input  clk,
    output in_valid, x, rm, is_unsigned, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  clk,
    input  in_valid, x, rm, is_unsigned, out_ready,
    output in_ready, out_valid, y, flags
  );

endinterface

// File: rtl/ftoi_core.sv
// Combinational binary32 -> integer conversion: decode, align, round per
// mode, negate and saturate to OUT_W bits with {invalid, inexact} flags.
module ftoi_core
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [F32_W-1:0] x_i,
  input  logic [2:0]       rm_i,
  input  logic             is_unsigned_i,
  output logic [OUT_W-1:0] y_o,
  output flags_t           flags_o
);

  // Value held with F32_MAN_W+1 fraction bits so the guard bit always lands at a fixed place.
  localparam int WIDE_W = OUT_W + F32_MAN_W + 1;
  localparam logic [F32_EXP_W-1:0] ALIGN_EXP = F32_EXP_W'(F32_BIAS - 1);
  localparam logic [F32_EXP_W:0]   HUGE_EXP  = (F32_EXP_W+1)'(F32_BIAS + OUT_W);
  localparam logic [OUT_W-1:0]     ONE_W     = OUT_W'(1);

  function automatic logic round_inc(input logic [2:0] mode, input logic neg,
                                     input logic lsb, input logic g, input logic st);
    case (mode)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return neg & (g | st);
      RM_RUP:  return ~neg & (g | st);
      RM_RMM:  return g;
      default: return g & (st | lsb);
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] sat_bound(input logic neg, input logic uns);
    if (uns) return neg ? '0 : '1;
    return neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  logic                 sign;
  logic [F32_EXP_W-1:0] exp;
  logic [F32_MAN_W-1:0] man;
  logic [F32_EXP_W-1:0] shamt;
  logic [WIDE_W-1:0]    wide;
  logic [OUT_W-1:0]     int_part;
  logic                 guard, sticky, inc;
  logic [OUT_W:0]       mag;
  logic                 special, eff_neg, pos_ovf, neg_ovf;

  always_comb begin
    sign     = x_i[F32_W-1];
    exp      = x_i[F32_W-2:F32_MAN_W];
    man      = x_i[F32_MAN_W-1:0];
    shamt    = exp - ALIGN_EXP;
    wide     = {{OUT_W{1'b0}}, 1'b1, man} << shamt;
    int_part = wide[WIDE_W-1:F32_MAN_W+1];
    guard    = wide[F32_MAN_W];
    sticky   = |wide[F32_MAN_W-1:0];
    if (exp < ALIGN_EXP) begin
      int_part = '0;
      guard    = 1'b0;
      sticky   = 1'b1;
    end

    inc = round_inc(rm_i, sign, int_part[0], guard, sticky);
    mag = {1'b0, int_part} + {{OUT_W{1'b0}}, inc};

    // NaN of either sign saturates high; Inf and out-of-range exponents follow the sign.
    special = (exp == F32_EXP_MAX) | ({1'b0, exp} >= HUGE_EXP);
    eff_neg = sign & ~((exp == F32_EXP_MAX) & (man != '0));
    if (special) begin
      pos_ovf = ~eff_neg;
      neg_ovf = eff_neg;
    end else if (is_unsigned_i) begin
      pos_ovf = ~sign & mag[OUT_W];
      neg_ovf = sign & (mag != '0);
    end else begin
      pos_ovf = ~sign & (mag[OUT_W] | mag[OUT_W-1]);
      neg_ovf = sign & (mag[OUT_W] | (mag[OUT_W-1] & (|mag[OUT_W-2:0])));
    end

    y_o     = sign ? (~mag[OUT_W-1:0] + ONE_W) : mag[OUT_W-1:0];
    flags_o = '{invalid: 1'b0, inexact: guard | sticky};
    if (exp == '0) begin
      y_o     = '0;
      flags_o = '0;
    end else if (pos_ovf | neg_ovf) begin
      y_o     = sat_bound(neg_ovf, is_unsigned_i);
      flags_o = '{invalid: 1'b1, inexact: 1'b0};
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Pipelined float-to-integer converter: ftoi_core result captured at stage 1,
// then retimed through the remaining stages under one global advance enable.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F32_W-1:0] x,
  input  logic [2:0]       rm,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic [1:0]       flags
);

  logic [OUT_W-1:0] core_y;
  flags_t           core_flags;

  ftoi_core #(.OUT_W(OUT_W)) u_core (
    .x_i           (x),
    .rm_i          (rm),
    .is_unsigned_i (is_unsigned),
    .y_o           (core_y),
    .flags_o       (core_flags)
  );

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0][OUT_W-1:0] y_q, y_d;
  logic [STAGES-1:0][1:0]       flg_q, flg_d;
  logic                         en;

  // A stalled output freezes every stage, so in_ready depends only on out_ready and out_valid.
  assign en        = ~vld_q[STAGES-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign y         = y_q[STAGES-1];
  assign flags     = flg_q[STAGES-1];

  always_comb begin
    vld_d    = vld_q;
    y_d      = y_q;
    flg_d    = flg_q;
    vld_d[0] = in_valid;
    y_d[0]   = core_y;
    flg_d[0] = core_flags;
    for (int i = 1; i < STAGES; i++) begin
      vld_d[i] = vld_q[i-1];
      y_d[i]   = y_q[i-1];
      flg_d[i] = flg_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      y_q   <= '0;
      flg_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
      y_q   <= y_d;
      flg_q <= flg_d;
    end
  end

endmodule
